// File: rtl/nfc_physical_output_sequencer.sv
// ---------------------------------------------------------------------------
// nfc_physical_output_sequencer
//
// Pin-output stage for the NAND flash controller. Timed pin words coming from
// the timing generators are buffered in a small FIFO and each one is driven
// onto registered pins for iWordHold+1 clock cycles. Before a word that drives
// DQ or DQS follows a period where the bus was not driven, a run of
// TurnaroundCycles high-Z cycles is inserted so that the NAND releases the bus
// before we start driving it. When the FIFO runs dry the pins fall back to
// safe idle levels. iFlush discards everything buffered and in flight.
//
// Ports
//   iSystemClock            clock, rising edge
//   iModuleReset            asynchronous active-low reset
//   iWordValid/oWordReady   word handshake (accepted when both high)
//   iWordDQ .. iWordHold    fields of the offered pin word
//   iFlush                  discard buffered and current words
//   oDQToNAND, oDQOutEnableToPinpad, oDQSToNAND, oDQSOutEnableToPinpad,
//   oCEToNAND, oWEToNAND, oREToNAND, oALEToNAND, oCLEToNAND   registered pins
//   oFifoLevel              buffered word count (registered)
//   oBusy                   sequencer active or words buffered (registered)
// ---------------------------------------------------------------------------
module nfc_physical_output_sequencer #(
  parameter int NumberOfWays     = 4,
  parameter int DataWidth        = 8,
  parameter int FifoDepth        = 8,
  parameter int TurnaroundCycles = 2
) (
  input  logic                           iSystemClock,
  input  logic                           iModuleReset,
  input  logic                           iWordValid,
  output logic                           oWordReady,
  input  logic [DataWidth-1:0]           iWordDQ,
  input  logic                           iWordDQOutEnable,
  input  logic                           iWordDQS,
  input  logic                           iWordDQSOutEnable,
  input  logic [NumberOfWays-1:0]        iWordCE,
  input  logic                           iWordWE,
  input  logic                           iWordRE,
  input  logic                           iWordALE,
  input  logic                           iWordCLE,
  input  logic [7:0]                     iWordHold,
  input  logic                           iFlush,
  output logic [DataWidth-1:0]           oDQToNAND,
  output logic [DataWidth-1:0]           oDQOutEnableToPinpad,
  output logic                           oDQSToNAND,
  output logic                           oDQSOutEnableToPinpad,
  output logic [NumberOfWays-1:0]        oCEToNAND,
  output logic                           oWEToNAND,
  output logic                           oREToNAND,
  output logic                           oALEToNAND,
  output logic                           oCLEToNAND,
  output logic [$clog2(FifoDepth):0]     oFifoLevel,
  output logic                           oBusy
);

  localparam int AddrWidth  = $clog2(FifoDepth);
  localparam int LevelWidth = AddrWidth + 1;
  // DQ + CE + {DQOE, DQS, DQSOE, WE, RE, ALE, CLE} + 8-bit hold
  localparam int WordWidth  = DataWidth + NumberOfWays + 15;
  localparam int TurnWidth  = (TurnaroundCycles > 1) ? $clog2(TurnaroundCycles) : 1;
  // Counter counts down to zero, so it is loaded with one less than the run.
  localparam int TurnLoad   = (TurnaroundCycles > 0) ? TurnaroundCycles - 1 : 0;

  typedef enum logic [1:0] {
    StIdle,
    StTurn,
    StPresent
  } stateT;

  // -------------------------------------------------------------------------
  // Word FIFO
  // -------------------------------------------------------------------------
  logic [WordWidth-1:0]  fifoMem [FifoDepth];
  logic [AddrWidth-1:0]  wrPtrReg, rdPtrReg;
  logic [LevelWidth-1:0] levelReg, levelNext;
  logic                  fifoFull, fifoEmpty;
  logic                  pushFifo, popFifo;
  logic [WordWidth-1:0]  inWord, headWord;

  assign inWord = {iWordDQ, iWordDQOutEnable, iWordDQS, iWordDQSOutEnable,
                   iWordCE, iWordWE, iWordRE, iWordALE, iWordCLE, iWordHold};

  assign fifoFull   = (levelReg == LevelWidth'(FifoDepth));
  assign fifoEmpty  = (levelReg == '0);
  assign oWordReady = !fifoFull && !iFlush;
  assign pushFifo   = iWordValid && oWordReady;
  assign headWord   = fifoMem[rdPtrReg];

  // Storage carries no reset; validity is tracked purely by the level.
  always_ff @(posedge iSystemClock) begin
    if (pushFifo) begin
      fifoMem[wrPtrReg] <= inWord;
    end
  end

  always_ff @(posedge iSystemClock or negedge iModuleReset) begin
    if (!iModuleReset) begin
      wrPtrReg <= '0;
      rdPtrReg <= '0;
    end else if (iFlush) begin
      wrPtrReg <= '0;
      rdPtrReg <= '0;
    end else begin
      if (pushFifo) wrPtrReg <= wrPtrReg + 1'b1;
      if (popFifo)  rdPtrReg <= rdPtrReg + 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Sequencer state and pin registers
  // -------------------------------------------------------------------------
  stateT                   stateReg, stateNext;
  logic [WordWidth-1:0]    curWordReg, curWordNext;
  logic [7:0]              holdCntReg, holdCntNext;
  logic [TurnWidth-1:0]    turnCntReg, turnCntNext;
  logic                    lastOEReg, lastOENext;
  logic                    busyReg, busyNext;

  logic [DataWidth-1:0]    dqReg, dqNext;
  logic                    dqOeReg, dqOeNext;
  logic                    dqsReg, dqsNext;
  logic                    dqsOeReg, dqsOeNext;
  logic [NumberOfWays-1:0] ceReg, ceNext;
  logic                    weReg, weNext;
  logic                    reReg, reNext;
  logic                    aleReg, aleNext;
  logic                    cleReg, cleNext;

  // The word being loaded comes from the FIFO head, except when a turnaround
  // finishes: then it is the pending word parked in curWordReg.
  logic [WordWidth-1:0]    srcWord;
  logic [DataWidth-1:0]    srcDQ;
  logic                    srcDQOE, srcDQS, srcDQSOE;
  logic [NumberOfWays-1:0] srcCE;
  logic                    srcWE, srcRE, srcALE, srcCLE;
  logic [7:0]              srcHold;
  logic                    srcOE;

  assign srcWord = (stateReg == StTurn) ? curWordReg : headWord;
  assign {srcDQ, srcDQOE, srcDQS, srcDQSOE, srcCE,
          srcWE, srcRE, srcALE, srcCLE, srcHold} = srcWord;
  assign srcOE = srcDQOE | srcDQSOE;

  logic loadHead, showSrc, goIdle;

  always_comb begin
    stateNext   = stateReg;
    curWordNext = curWordReg;
    holdCntNext = holdCntReg;
    turnCntNext = turnCntReg;
    lastOENext  = lastOEReg;
    dqNext      = dqReg;
    dqOeNext    = dqOeReg;
    dqsNext     = dqsReg;
    dqsOeNext   = dqsOeReg;
    ceNext      = ceReg;
    weNext      = weReg;
    reNext      = reReg;
    aleNext     = aleReg;
    cleNext     = cleReg;
    popFifo     = 1'b0;
    loadHead    = 1'b0;
    showSrc     = 1'b0;
    goIdle      = 1'b0;
    levelNext   = levelReg;
    busyNext    = busyReg;

    case (stateReg)
      StIdle: begin
        if (!fifoEmpty) loadHead = 1'b1;
      end
      StTurn: begin
        if (turnCntReg == '0) showSrc = 1'b1;
        else                  turnCntNext = turnCntReg - 1'b1;
      end
      StPresent: begin
        if (holdCntReg == 8'd0) begin
          // Last cycle of the word: chain the next one with no gap if present.
          if (!fifoEmpty) loadHead = 1'b1;
          else            goIdle   = 1'b1;
        end else begin
          holdCntNext = holdCntReg - 8'd1;
        end
      end
      default: goIdle = 1'b1;
    endcase

    if (loadHead) begin
      popFifo     = 1'b1;
      curWordNext = headWord;
      // Bus was released by the previous word (or never driven): give the
      // NAND time to stop driving before we take DQ/DQS.
      if (srcOE && !lastOEReg && (TurnaroundCycles > 0)) begin
        stateNext   = StTurn;
        turnCntNext = TurnWidth'(TurnLoad);
        dqOeNext    = 1'b0;
        dqsNext     = 1'b0;
        dqsOeNext   = 1'b0;
        weNext      = 1'b1;
        reNext      = 1'b1;
        ceNext      = srcCE;
        aleNext     = srcALE;
        cleNext     = srcCLE;
      end else begin
        showSrc = 1'b1;
      end
    end

    if (showSrc) begin
      stateNext   = StPresent;
      holdCntNext = srcHold;
      lastOENext  = srcOE;
      dqNext      = srcDQ;
      dqOeNext    = srcDQOE;
      dqsNext     = srcDQS;
      dqsOeNext   = srcDQSOE;
      ceNext      = srcCE;
      weNext      = srcWE;
      reNext      = srcRE;
      aleNext     = srcALE;
      cleNext     = srcCLE;
    end

    // Idle levels: DQ and CE keep their last values so the selected chip
    // stays selected across an underrun.
    if (goIdle || iFlush) begin
      stateNext  = StIdle;
      lastOENext = 1'b0;
      dqOeNext   = 1'b0;
      dqsNext    = 1'b0;
      dqsOeNext  = 1'b0;
      weNext     = 1'b1;
      reNext     = 1'b1;
      aleNext    = 1'b0;
      cleNext    = 1'b0;
      popFifo    = 1'b0;
    end

    if (iFlush) begin
      levelNext = '0;
    end else if (pushFifo && !popFifo) begin
      levelNext = levelReg + LevelWidth'(1);
    end else if (popFifo && !pushFifo) begin
      levelNext = levelReg - LevelWidth'(1);
    end

    busyNext = (stateNext != StIdle) || (levelNext != '0);
  end

  always_ff @(posedge iSystemClock or negedge iModuleReset) begin
    if (!iModuleReset) begin
      stateReg   <= StIdle;
      curWordReg <= '0;
      holdCntReg <= '0;
      turnCntReg <= '0;
      lastOEReg  <= 1'b0;
      levelReg   <= '0;
      busyReg    <= 1'b0;
      dqReg      <= '0;
      dqOeReg    <= 1'b0;
      dqsReg     <= 1'b0;
      dqsOeReg   <= 1'b0;
      ceReg      <= '1;
      weReg      <= 1'b1;
      reReg      <= 1'b1;
      aleReg     <= 1'b0;
      cleReg     <= 1'b0;
    end else begin
      stateReg   <= stateNext;
      curWordReg <= curWordNext;
      holdCntReg <= holdCntNext;
      turnCntReg <= turnCntNext;
      lastOEReg  <= lastOENext;
      levelReg   <= levelNext;
      busyReg    <= busyNext;
      dqReg      <= dqNext;
      dqOeReg    <= dqOeNext;
      dqsReg     <= dqsNext;
      dqsOeReg   <= dqsOeNext;
      ceReg      <= ceNext;
      weReg      <= weNext;
      reReg      <= reNext;
      aleReg     <= aleNext;
      cleReg     <= cleNext;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < DataWidth; gi++) begin : gDqOe
      assign oDQOutEnableToPinpad[gi] = dqOeReg;
    end
  endgenerate

  assign oDQToNAND             = dqReg;
  assign oDQSToNAND            = dqsReg;
  assign oDQSOutEnableToPinpad = dqsOeReg;
  assign oCEToNAND             = ceReg;
  assign oWEToNAND             = weReg;
  assign oREToNAND             = reReg;
  assign oALEToNAND            = aleReg;
  assign oCLEToNAND            = cleReg;
  assign oFifoLevel            = levelReg;
  assign oBusy                 = busyReg;

endmodule

// File: tb/tb_nfc_physical_output_sequencer.sv
// ---------------------------------------------------------------------------
// tb_nfc_physical_output_sequencer
//
// Directed bench for nfc_physical_output_sequencer with default parameters
// (4 ways, 8-bit DQ, 8-entry FIFO, 2 turnaround cycles). Inputs change 1 time
// unit after a rising edge and outputs are sampled at the same point, so each
// observation reflects the state registered at the preceding edge.
// ---------------------------------------------------------------------------
module tb_nfc_physical_output_sequencer;

  logic       clk = 1'b0;
  logic       rstN;
  logic       iWordValid;
  logic       oWordReady;
  logic [7:0] iWordDQ;
  logic       iWordDQOutEnable;
  logic       iWordDQS;
  logic       iWordDQSOutEnable;
  logic [3:0] iWordCE;
  logic       iWordWE, iWordRE, iWordALE, iWordCLE;
  logic [7:0] iWordHold;
  logic       iFlush;
  logic [7:0] oDQToNAND;
  logic [7:0] oDQOutEnableToPinpad;
  logic       oDQSToNAND, oDQSOutEnableToPinpad;
  logic [3:0] oCEToNAND;
  logic       oWEToNAND, oREToNAND, oALEToNAND, oCLEToNAND;
  logic [3:0] oFifoLevel;
  logic       oBusy;

  int checks   = 0;
  int failures = 0;

  nfc_physical_output_sequencer dut (
    .iSystemClock          (clk),
    .iModuleReset          (rstN),
    .iWordValid            (iWordValid),
    .oWordReady            (oWordReady),
    .iWordDQ               (iWordDQ),
    .iWordDQOutEnable      (iWordDQOutEnable),
    .iWordDQS              (iWordDQS),
    .iWordDQSOutEnable     (iWordDQSOutEnable),
    .iWordCE               (iWordCE),
    .iWordWE               (iWordWE),
    .iWordRE               (iWordRE),
    .iWordALE              (iWordALE),
    .iWordCLE              (iWordCLE),
    .iWordHold             (iWordHold),
    .iFlush                (iFlush),
    .oDQToNAND             (oDQToNAND),
    .oDQOutEnableToPinpad  (oDQOutEnableToPinpad),
    .oDQSToNAND            (oDQSToNAND),
    .oDQSOutEnableToPinpad (oDQSOutEnableToPinpad),
    .oCEToNAND             (oCEToNAND),
    .oWEToNAND             (oWEToNAND),
    .oREToNAND             (oREToNAND),
    .oALEToNAND            (oALEToNAND),
    .oCLEToNAND            (oCLEToNAND),
    .oFifoLevel            (oFifoLevel),
    .oBusy                 (oBusy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected pin vector: {DQ, DQ OE x8, DQS, DQS OE, CE, WE, RE, ALE, CLE}
  function automatic logic [31:0] mk(input logic [7:0] dq, input logic oe,
                                     input logic dqs, input logic dqsOe,
                                     input logic [3:0] ce, input logic we,
                                     input logic re, input logic ale,
                                     input logic cle);
    return {6'd0, dq, {8{oe}}, dqs, dqsOe, ce, we, re, ale, cle};
  endfunction

  function automatic logic [31:0] pinsNow();
    return {6'd0, oDQToNAND, oDQOutEnableToPinpad, oDQSToNAND,
            oDQSOutEnableToPinpad, oCEToNAND, oWEToNAND, oREToNAND,
            oALEToNAND, oCLEToNAND};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic setWord(input logic [7:0] dq, input logic dqOe,
                         input logic dqs, input logic dqsOe,
                         input logic [3:0] ce, input logic we, input logic re,
                         input logic ale, input logic cle,
                         input logic [7:0] hold);
    iWordDQ           = dq;
    iWordDQOutEnable  = dqOe;
    iWordDQS          = dqs;
    iWordDQSOutEnable = dqsOe;
    iWordCE           = ce;
    iWordWE           = we;
    iWordRE           = re;
    iWordALE          = ale;
    iWordCLE          = cle;
    iWordHold         = hold;
  endtask

  initial begin
    rstN       = 1'b0;
    iWordValid = 1'b0;
    iFlush     = 1'b0;
    setWord(8'h00, 1'b0, 1'b0, 1'b0, 4'hF, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);

    // ---- reset values ----
    step();
    step();
    check("reset_pins",  pinsNow(), mk(8'h00, 0, 0, 0, 4'hF, 1, 1, 0, 0));
    check("reset_level", 32'(oFifoLevel), 32'd0);
    check("reset_busy",  32'(oBusy), 32'd0);
    rstN = 1'b1;
    step();

    // ---- single word with turnaround: A5, hold 3 ----
    setWord(8'hA5, 1'b1, 1'b0, 1'b0, 4'hE, 1'b0, 1'b1, 1'b1, 1'b0, 8'd3);
    iWordValid = 1'b1;
    check("t2_ready", 32'(oWordReady), 32'd1);
    step();                                   // word accepted
    iWordValid = 1'b0;
    check("t2_level1", 32'(oFifoLevel), 32'd1);
    check("t2_busy1",  32'(oBusy), 32'd1);
    for (int i = 0; i < 2; i++) begin
      step();
      check($sformatf("t2_turn%0d", i), pinsNow(),
            mk(8'h00, 0, 0, 0, 4'hE, 1, 1, 1, 0));
    end
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("t2_word%0d", i), pinsNow(),
            mk(8'hA5, 1, 0, 0, 4'hE, 0, 1, 1, 0));
    end
    check("t2_busy_last", 32'(oBusy), 32'd1);
    step();
    check("t2_idle", pinsNow(), mk(8'hA5, 0, 0, 0, 4'hE, 1, 1, 0, 0));
    check("t2_busy0", 32'(oBusy), 32'd0);

    // ---- three back-to-back words, hold 0, all driving ----
    setWord(8'h11, 1'b1, 1'b1, 1'b1, 4'hD, 1'b1, 1'b0, 1'b0, 1'b1, 8'd0);
    iWordValid = 1'b1;
    step();
    iWordDQ = 8'h22;
    step();
    check("t3_turn0", pinsNow(), mk(8'hA5, 0, 0, 0, 4'hD, 1, 1, 0, 1));
    iWordDQ = 8'h33;
    step();
    iWordValid = 1'b0;
    check("t3_turn1", pinsNow(), mk(8'hA5, 0, 0, 0, 4'hD, 1, 1, 0, 1));
    check("t3_level", 32'(oFifoLevel), 32'd2);
    step();
    check("t3_w1", pinsNow(), mk(8'h11, 1, 1, 1, 4'hD, 1, 0, 0, 1));
    step();
    check("t3_w2", pinsNow(), mk(8'h22, 1, 1, 1, 4'hD, 1, 0, 0, 1));
    step();
    check("t3_w3", pinsNow(), mk(8'h33, 1, 1, 1, 4'hD, 1, 0, 0, 1));
    step();
    check("t3_idle", pinsNow(), mk(8'h33, 0, 0, 0, 4'hD, 1, 1, 0, 0));

    // ---- OE=0 word then DQS-driving word: turnaround between them ----
    setWord(8'h44, 1'b0, 1'b0, 1'b0, 4'hB, 1'b0, 1'b1, 1'b0, 1'b1, 8'd1);
    iWordValid = 1'b1;
    step();
    setWord(8'h55, 1'b0, 1'b1, 1'b1, 4'h7, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0);
    step();
    iWordValid = 1'b0;
    check("t4_w4a", pinsNow(), mk(8'h44, 0, 0, 0, 4'hB, 0, 1, 0, 1));
    step();
    check("t4_w4b", pinsNow(), mk(8'h44, 0, 0, 0, 4'hB, 0, 1, 0, 1));
    step();
    check("t4_turn0", pinsNow(), mk(8'h44, 0, 0, 0, 4'h7, 1, 1, 1, 0));
    step();
    check("t4_turn1", pinsNow(), mk(8'h44, 0, 0, 0, 4'h7, 1, 1, 1, 0));
    step();
    check("t4_w5", pinsNow(), mk(8'h55, 0, 1, 1, 4'h7, 1, 1, 1, 0));
    step();
    check("t4_idle", pinsNow(), mk(8'h55, 0, 0, 0, 4'h7, 1, 1, 0, 0));

    // ---- fill FIFO behind a 256-cycle word ----
    setWord(8'h60, 1'b0, 1'b0, 1'b0, 4'hE, 1'b0, 1'b1, 1'b0, 1'b0, 8'd255);
    iWordValid = 1'b1;
    step();
    for (int i = 0; i < 8; i++) begin
      setWord(8'(8'h70 + i), 1'b0, 1'b0, 1'b0, 4'hE, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
      step();
    end
    iWordDQ = 8'hEE;
    check("t5_full_level", 32'(oFifoLevel), 32'd8);
    check("t5_full_ready", 32'(oWordReady), 32'd0);
    repeat (248) step();
    check("t5_stall_pins",  pinsNow(), mk(8'h60, 0, 0, 0, 4'hE, 0, 1, 0, 0));
    check("t5_stall_ready", 32'(oWordReady), 32'd0);
    step();
    iWordValid = 1'b0;
    check("t5_pop_level", 32'(oFifoLevel), 32'd7);
    check("t5_pop_ready", 32'(oWordReady), 32'd1);
    check("t5_pop_pins",  pinsNow(), mk(8'h70, 0, 0, 0, 4'hE, 0, 1, 0, 0));
    for (int i = 0; i < 20 && oBusy; i++) step();
    check("t5_drained", 32'(oBusy), 32'd0);
    check("t5_last_dq", 32'(oDQToNAND), 32'h77);

    // ---- flush with 5 buffered words and a word on offer ----
    setWord(8'h80, 1'b0, 1'b0, 1'b0, 4'h3, 1'b0, 1'b0, 1'b1, 1'b1, 8'd255);
    iWordValid = 1'b1;
    step();
    for (int i = 1; i <= 5; i++) begin
      setWord(8'(8'h80 + i), 1'b0, 1'b0, 1'b0, 4'h3, 1'b0, 1'b0, 1'b1, 1'b1, 8'd0);
      step();
    end
    iWordDQ = 8'h99;
    check("t6_pre_level", 32'(oFifoLevel), 32'd5);
    check("t6_pre_pins",  pinsNow(), mk(8'h80, 0, 0, 0, 4'h3, 0, 0, 1, 1));
    iFlush = 1'b1;
    #1;
    check("t6_flush_ready", 32'(oWordReady), 32'd0);
    step();
    iFlush     = 1'b0;
    iWordValid = 1'b0;
    check("t6_level", 32'(oFifoLevel), 32'd0);
    check("t6_busy",  32'(oBusy), 32'd0);
    check("t6_pins",  pinsNow(), mk(8'h80, 0, 0, 0, 4'h3, 1, 1, 0, 0));
    step();
    check("t6_after_level", 32'(oFifoLevel), 32'd0);
    check("t6_after_pins",  pinsNow(), mk(8'h80, 0, 0, 0, 4'h3, 1, 1, 0, 0));

    // ---- asynchronous reset in the middle of a presented word ----
    setWord(8'hC3, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd10);
    iWordValid = 1'b1;
    step();
    iWordValid = 1'b0;
    step();
    step();
    step();
    check("t7_present", pinsNow(), mk(8'hC3, 1, 0, 0, 4'h0, 0, 0, 1, 1));
    #1;
    rstN = 1'b0;
    #1;
    check("t7_rst_pins",  pinsNow(), mk(8'h00, 0, 0, 0, 4'hF, 1, 1, 0, 0));
    check("t7_rst_busy",  32'(oBusy), 32'd0);
    check("t7_rst_level", 32'(oFifoLevel), 32'd0);
    step();
    rstN = 1'b1;
    step();
    check("t7_post_pins", pinsNow(), mk(8'h00, 0, 0, 0, 4'hF, 1, 1, 0, 0));
    check("t7_post_busy", 32'(oBusy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/nfc_physical_output_sequencer.md
# nfc_physical_output_sequencer

Parametrised NAND pin-output stage that succeeds the fixed-width ODDR output block: it buffers timed pin words (DQ, DQS, CE, WE, RE, ALE, CLE plus output enables) in a FIFO and drives each onto registered pins for a programmable number of cycles. It sits between the NFC timing generators and the pinpad. Over the fixed-width block it adds these parametrised capabilities: way count, data width, buffering depth, automatic DQ/DQS bus-turnaround insertion, idle pin levels on underrun, and flush.

## Interface
- NumberOfWays, 4, number of CE pins
- DataWidth, 8, DQ width
- FifoDepth, 8, word buffer entries (power of two, ≥2)
- TurnaroundCycles, 2, high-Z cycles inserted before driving DQ/DQS after bus was input (0 = none)

- iSystemClock  in  1  single clock, rising edge
- iModuleReset  in  1  asynchronous, active-low reset
- iWordValid  in  1  word offered
- oWordReady  out  1  word accepted when iWordValid & oWordReady
- iWordDQ  in  DataWidth  DQ value
- iWordDQOutEnable  in  1  drive DQ
- iWordDQS  in  1  DQS value
- iWordDQSOutEnable  in  1  drive DQS
- iWordCE  in  NumberOfWays  CE pin levels (active-low)
- iWordWE, iWordRE, iWordALE, iWordCLE  in  1 each  pin levels
- iWordHold  in  8  word is presented for iWordHold+1 cycles
- iFlush  in  1  discard buffered/current words
- oDQToNAND  out  DataWidth
- oDQOutEnableToPinpad  out  DataWidth  all bits equal
- oDQSToNAND, oDQSOutEnableToPinpad  out  1 each
- oCEToNAND  out  NumberOfWays
- oWEToNAND, oREToNAND, oALEToNAND, oCLEToNAND  out  1 each
- oFifoLevel  out  $clog2(FifoDepth)+1  buffered word count
- oBusy  out  1  FSM not IDLE or FIFO non-empty

## Operation
- FIFO: write on valid&ready; oWordReady = !full & !iFlush. Pop when the FSM loads a word.
- Idle levels: DQ holds last value, DQ/DQS OE 0, DQS 0, WE 1, RE 1, ALE 0, CLE 0, CE holds last value (chip stays selected across underrun).
- FSM states IDLE, TURN, PRESENT.
  - IDLE: FIFO non-empty → pop head; if head DQOutEnable|DQSOutEnable = 1 and lastOE = 0 and TurnaroundCycles > 0 → TURN, else → PRESENT with pins = word.
  - TURN: pins at idle levels except CE, ALE, CLE taken from the pending word; count TurnaroundCycles cycles, then → PRESENT.
  - PRESENT: pins = word, hold counter counts iWordHold+1 cycles. On last cycle: FIFO non-empty → load next word (same turnaround rule) with no gap; else → IDLE, pins go to idle levels.
- lastOE register = OE of the last presented word; cleared to 0 on entering IDLE; reset 0.
- iFlush (sampled high): FIFO emptied, current word/turnaround aborted, FSM → IDLE, pins idle levels next cycle; flush beats simultaneous write and pop.
- Hold counter 8-bit, no wrap: iWordHold=255 → 256 cycles.

## Timing
- Reset (asynchronous assert, synchronous-release assumed upstream): oDQToNAND 0, all OE 0, oDQSToNAND 0, oCEToNAND all 1, oWEToNAND 1, oREToNAND 1, oALEToNAND 0, oCLEToNAND 0, oFifoLevel 0, oBusy 0, FSM IDLE. Reset mid-word aborts instantly to these values.
- Latency: word accepted at edge k with FSM IDLE and no turnaround → pins show it from edge k+1 for iWordHold+1 cycles. With turnaround → pins show it from edge k+1+TurnaroundCycles.
- Back-to-back words with FIFO non-empty: zero idle cycles between them.
- Full: oWordReady low while oFifoLevel = FifoDepth; a pop and a write in the same cycle on a full FIFO is not allowed since ready is low. A pop and a write in the same cycle on a non-full FIFO is legal, and the level is unchanged.
- oFifoLevel and oBusy are registered and update at the same edge as the FIFO.

## Test plan
- Reset: assert iModuleReset=0 mid-PRESENT → all outputs take reset values immediately; CE=4'b1111, WE=RE=1.
- Single word DQ=8'hA5, OE=1, Hold=3, TurnaroundCycles=2, from IDLE → 2 cycles OE=0 with word CE/ALE/CLE, then DQ=A5, OE=8'hFF for exactly 4 cycles, then idle levels, oBusy falls.
- Three words Hold=0, all OE=1, written back-to-back → one turnaround pair, then three consecutive single-cycle words with no gap.
- Fill 8 words with FSM stalled on Hold=255 → oWordReady=0 at level 8; first pop at cycle 256 → ready=1 next cycle.
- Word OE=0 then word OE=1 → turnaround inserted between them; word OE=1 then OE=1 → none.
- iFlush asserted with 5 words buffered and valid=1 → level 0, word not accepted, pins idle next cycle, FSM IDLE.
